sp_unit_param: RTL
==================

# sp_unit_param

Parametrised stack-pointer unit for the execute/memory boundary of the pipeline. It supports a configurable address width, step size and stack window. Ops are PUSH, POP and a two-word PUSH2 used for CALL/interrupt frames. Each accepted op updates a speculative pointer that becomes architectural only on `commit` and is discarded on `flush`. Optional bounds checking raises sticky overflow/underflow flags and suppresses faulting ops.

## Interface
- `ADDR_W`, 32, width of SP and stack addresses
- `STEP`, 2, address decrement/increment per word; power of two
- `SP_TOP`, 32'h0000_0FFE, reset SP and highest stack slot; STEP-aligned
- `SP_BOTTOM`, 32'h0000_0F00, lowest legal slot; STEP-aligned, ≤ SP_TOP
- `CLK` in 1: single clock, rising edge
- `Reset` in 1: asynchronous, active-high
- `op_valid` in 1: op request
- `op` in 2: 00 NOP, 01 PUSH, 10 POP, 11 PUSH2
- `op_ready` out 1: op accepted when `op_valid & op_ready`
- `commit` in 1: make pending speculative SP architectural
- `flush` in 1: discard pending speculative SP
- `flag_clr` in 1: clear sticky flags
- `addr_valid` out 1: `addr_out` is a memory access address
- `addr_out` out ADDR_W: stack slot address for current word
- `sp_arch` out ADDR_W: committed SP
- `sp_spec` out ADDR_W: speculative SP
- `overflow` out 1: sticky, PUSH/PUSH2 beyond SP_BOTTOM
- `underflow` out 1: sticky, POP above SP_TOP

## Operation
- Stack is full-descending. SP names the next free slot.
- PUSH: address = SP; SP_spec ← SP − STEP.
- POP: address = SP + STEP; SP_spec ← SP + STEP.
- PUSH2: address SP, then SP − STEP; SP_spec ← SP − 2·STEP.
- NOP: accepted, no effect, no pending state.
- All arithmetic is modulo 2^ADDR_W.
- FSM states:
  - IDLE: `op_ready`=1.
    - PUSH/POP → PENDING.
    - PUSH2 → PUSH2_B.
  - PUSH2_B: emits second address, `op_ready`=0; → PENDING.
  - PENDING: `op_ready` = `commit`; holds until `commit` or `flush`.
    - `commit`: SP_arch ← SP_spec.
    - `flush`: SP_spec ← SP_arch.
    - Either returns to IDLE, or accepts a new op the same cycle, computed from the committed value.
- `commit` and `flush` in the same cycle: `flush` wins.
- `commit`/`flush` outside PENDING: ignored.
- `flush` during PUSH2_B: second address is still emitted with `addr_valid`=0; state → IDLE, SP_spec ← SP_arch.
- Faulting op (bounds check enabled):
  - The op is consumed (`op_ready` handshake completes).
  - `addr_valid` stays 0, SP_spec is unchanged, state stays IDLE, and the sticky flag sets.
  - PUSH2 is checked atomically: both words must fit, or neither is issued.
- PUSH faults when SP < SP_BOTTOM.
- PUSH2 faults when SP − STEP < SP_BOTTOM.
- POP faults when SP ≥ SP_TOP.
- `flag_clr` clears the flags. If a fault and `flag_clr` occur in the same cycle, the fault wins.
- Reset values:
  - SP_arch = SP_spec = SP_TOP; state IDLE.
  - `addr_valid`=0, `addr_out`=0.
  - `overflow`=`underflow`=0.
  - `op_ready`=1.

## Timing
- `addr_out`/`addr_valid` are registered: valid 1 cycle after acceptance.
- PUSH2 second word: 2 cycles after acceptance.
- `sp_spec` updates 1 cycle after acceptance. `sp_arch` updates 1 cycle after `commit`.
- Flags assert 1 cycle after the faulting handshake.
- Reset asserted mid-operation forces all reset values immediately. Any pending op is lost.

## Configuration
- `SP_BOUNDS_CHECK_EN` defined: bounds checking and sticky flags are implemented as above.
- `SP_BOUNDS_CHECK_EN` undefined:
  - No checks; SP wraps freely modulo 2^ADDR_W.
  - `overflow`/`underflow` are tied 0.
  - `flag_clr` is ignored.

## Structure
- Shared package `sp_pkg`:
  - op encodings (`SP_NOP`, `SP_PUSH`, `SP_POP`, `SP_PUSH2`)
  - FSM state enum
- Sub-module `sp_bounds_check`: combinational fault detection from SP, op, STEP, SP_TOP, SP_BOTTOM. Instantiated only under `SP_BOUNDS_CHECK_EN`.

## Test plan
- Reset:
  - Assert Reset mid-PUSH2 → next cycle `sp_arch`=`sp_spec`=0xFFE, `addr_valid`=0, flags 0.
- PUSH then commit:
  - `addr_out`=0xFFE 1 cycle later.
  - `sp_spec`=0xFFC; `sp_arch`=0xFFC after `commit`.
- POP then flush:
  - From SP=0xFFC, POP → `addr_out`=0xFFE, `sp_spec`=0xFFE.
  - `flush` → `sp_spec`=0xFFC, `sp_arch` unchanged.
- PUSH2 with commit plus back-to-back PUSH:
  - From 0xFFE: addresses 0xFFE then 0xFFC, SP→0xFFA.
  - `commit` together with a new PUSH → next address 0xFFA.
- Overflow:
  - 128 committed PUSHes → SP=0xEFE.
  - 129th PUSH → `overflow`=1, `addr_valid`=0, SP unchanged.
  - `flag_clr` → 0.
- Underflow and atomic PUSH2:
  - POP at 0xFFE → `underflow`=1.
  - PUSH2 at SP=0xF00 → `overflow`=1, no address issued.
  - Without `SP_BOUNDS_CHECK_EN`: same PUSH2 issues 0xF00 and 0xEFE.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared definitions for the stack-pointer unit: op encodings and FSM states.
package sp_pkg;

    // Op encodings as they appear on the op port
    typedef enum logic [1:0] {
        SP_NOP   = 2'b00,
        SP_PUSH  = 2'b01,
        SP_POP   = 2'b10,
        SP_PUSH2 = 2'b11
    } sp_op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PUSH2_B = 2'b01,
        ST_PENDING = 2'b10
    } sp_state_e;

endpackage

// File: rtl/sp_bounds_check.sv
// Combinational stack-window fault detection for a candidate op.
// Only instantiated when SP_BOUNDS_CHECK_EN is defined.
module sp_bounds_check
    import sp_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       STEP      = 2,
    parameter logic [ADDR_W-1:0] SP_TOP    = ADDR_W'(32'h0000_0FFE),
    parameter logic [ADDR_W-1:0] SP_BOTTOM = ADDR_W'(32'h0000_0F00)
) (
    input  logic [ADDR_W-1:0] sp,
    input  logic [1:0]        op,
    output logic              overflow_fault,
    output logic              underflow_fault
);

    localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

    logic [ADDR_W-1:0] sp_minus_step;

    // PUSH2 is judged on its second slot so both words fit or neither issues
    always_comb begin
        sp_minus_step   = sp - STEP_W;
        overflow_fault  = 1'b0;
        underflow_fault = 1'b0;
        case (op)
            SP_PUSH:  overflow_fault  = (sp < SP_BOTTOM);
            SP_PUSH2: overflow_fault  = (sp_minus_step < SP_BOTTOM);
            SP_POP:   underflow_fault = (sp >= SP_TOP);
            default:  ;
        endcase
    end

endmodule

// File: rtl/sp_unit_param.sv
// Speculative/architectural stack-pointer unit (full-descending stack).
// Optional feature macro: SP_BOUNDS_CHECK_EN enables window checks and
// sticky overflow/underflow flags; without it SP wraps freely.
module sp_unit_param
    import sp_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       STEP      = 2,
    parameter logic [ADDR_W-1:0] SP_TOP    = ADDR_W'(32'h0000_0FFE),
    parameter logic [ADDR_W-1:0] SP_BOTTOM = ADDR_W'(32'h0000_0F00)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              op_valid,
    input  logic [1:0]        op,
    output logic              op_ready,
    input  logic              commit,
    input  logic              flush,
    input  logic              flag_clr,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic [ADDR_W-1:0] sp_arch,
    output logic [ADDR_W-1:0] sp_spec,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] STEP2_W = ADDR_W'(2 * STEP);

    sp_state_e         state_q, state_d;
    logic [ADDR_W-1:0] sp_arch_q, sp_arch_d;
    logic [ADDR_W-1:0] sp_spec_q, sp_spec_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic [ADDR_W-1:0] base_sp;
    logic              accept;
    logic              overflow_fault, underflow_fault;
    logic              set_ovf, set_unf;

    // Ready in IDLE; in PENDING only a committing cycle may take a new op
    always_comb begin
        case (state_q)
            ST_IDLE:    op_ready = 1'b1;
            ST_PENDING: op_ready = commit;
            default:    op_ready = 1'b0;
        endcase
    end

    assign accept = op_valid & op_ready;

    // A new op builds on the committed value: the pending SP when it commits
    // this cycle, otherwise the architectural SP (also equal to spec in IDLE)
    assign base_sp = (state_q == ST_PENDING && commit && !flush) ? sp_spec_q : sp_arch_q;

`ifdef SP_BOUNDS_CHECK_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    sp_bounds_check #(
        .ADDR_W    (ADDR_W),
        .STEP      (STEP),
        .SP_TOP    (SP_TOP),
        .SP_BOTTOM (SP_BOTTOM)
    ) u_bounds_check (
        .sp              (base_sp),
        .op              (op),
        .overflow_fault  (overflow_fault),
        .underflow_fault (underflow_fault)
    );

    // Sticky flags: a fault in the same cycle as a clear keeps the flag set
    always_comb begin
        ovf_d = set_ovf | (ovf_q & ~flag_clr);
        unf_d = set_unf | (unf_q & ~flag_clr);
    end

    // Flag registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_cfg;

    assign overflow_fault  = 1'b0;
    assign underflow_fault = 1'b0;
    assign overflow        = 1'b0;
    assign underflow       = 1'b0;
    // Clear input and lower bound have no role without checking
    assign unused_cfg      = flag_clr ^ (^SP_BOTTOM) ^ set_ovf ^ set_unf;
`endif

    // Next-state: resolve PUSH2 second word / pending commit-flush, then new op
    always_comb begin
        state_d      = state_q;
        sp_arch_d    = sp_arch_q;
        sp_spec_d    = sp_spec_q;
        addr_d       = addr_q;
        addr_valid_d = 1'b0;
        set_ovf      = 1'b0;
        set_unf      = 1'b0;

        case (state_q)
            ST_PUSH2_B: begin
                // Second slot sits one step above the already-updated spec SP
                addr_d = sp_spec_q + STEP_W;
                if (flush) begin
                    sp_spec_d = sp_arch_q;
                    state_d   = ST_IDLE;
                end else begin
                    addr_valid_d = 1'b1;
                    state_d      = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (flush) begin
                    sp_spec_d = sp_arch_q;
                    state_d   = ST_IDLE;
                end else if (commit) begin
                    sp_arch_d = sp_spec_q;
                    state_d   = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (accept && op != SP_NOP) begin
            if (overflow_fault) begin
                set_ovf = 1'b1;
            end else if (underflow_fault) begin
                set_unf = 1'b1;
            end else begin
                addr_valid_d = 1'b1;
                case (op)
                    SP_PUSH: begin
                        addr_d    = base_sp;
                        sp_spec_d = base_sp - STEP_W;
                        state_d   = ST_PENDING;
                    end
                    SP_POP: begin
                        addr_d    = base_sp + STEP_W;
                        sp_spec_d = base_sp + STEP_W;
                        state_d   = ST_PENDING;
                    end
                    default: begin
                        addr_d    = base_sp;
                        sp_spec_d = base_sp - STEP2_W;
                        state_d   = ST_PUSH2_B;
                    end
                endcase
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            sp_arch_q    <= SP_TOP;
            sp_spec_q    <= SP_TOP;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_arch_q    <= sp_arch_d;
            sp_spec_q    <= sp_spec_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    assign addr_valid = addr_valid_q;
    assign addr_out   = addr_q;
    assign sp_arch    = sp_arch_q;
    assign sp_spec    = sp_spec_q;

endmodule
